// File: rtl/hazard_id_ex_stage_if.sv
// ID/EX boundary bundle: decoded ID operands in, registered EX operands plus
// pipeline-control enables out.
interface hazard_id_ex_stage_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [31:0] id_read_data1;
  logic [31:0] id_read_data2;
  logic [31:0] id_imm;
  logic [7:0]  id_ctrl;
  logic        flush;

  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_rd;
  logic [31:0] ex_read_data1;
  logic [31:0] ex_read_data2;
  logic [31:0] ex_imm;
  logic [7:0]  ex_ctrl;
  logic        pc_write;
  logic        if_id_write;
  logic        stall;
  logic [15:0] stall_count;

  // Master is the ID side that presents instructions; slave is the stage.
  modport master (
    output id_rs, id_rt, id_rd, id_read_data1, id_read_data2, id_imm, id_ctrl, flush,
    input  ex_rs, ex_rt, ex_rd, ex_read_data1, ex_read_data2, ex_imm, ex_ctrl,
    input  pc_write, if_id_write, stall, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_rd, id_read_data1, id_read_data2, id_imm, id_ctrl, flush,
    output ex_rs, ex_rt, ex_rd, ex_read_data1, ex_read_data2, ex_imm, ex_ctrl,
    output pc_write, if_id_write, stall, stall_count
  );
endinterface

// File: rtl/hazard_id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, one-cycle bubble
// insertion, branch-flush squash and a saturating stall-cycle counter.
module hazard_id_ex_stage (
  input logic               clk,
  input logic               reset,
  hazard_id_ex_stage_if.slave bus
);

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_e;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [31:0] imm;
  } stage_t;

  localparam logic [15:0] STALL_COUNT_MAX = 16'hFFFF;

  state_e      state_q, state_d;
  stage_t      ex_q, ex_d;
  stage_t      id_pkt;
  logic [15:0] stall_count_q, stall_count_d;
  logic        hazard;
  logic        stall;

  assign id_pkt = '{rs:         bus.id_rs,
                    rt:         bus.id_rt,
                    rd:         bus.id_rd,
                    ctrl:       bus.id_ctrl,
                    read_data1: bus.id_read_data1,
                    read_data2: bus.id_read_data2,
                    imm:        bus.id_imm};

  // id_rt is compared for every instruction type; occasional false stalls on
  // I-type consumers are cheaper than decoding the format here.
  assign hazard = ex_q.ctrl[6] && (ex_q.rt != 5'd0) &&
                  ((ex_q.rt == bus.id_rs) || (ex_q.rt == bus.id_rt));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d       = state_q;
    ex_d          = id_pkt;
    stall_count_d = stall_count_q;

    stall = hazard && !bus.flush && !reset;

    if (stall || bus.flush) begin
      ex_d = '0;
    end

    if (stall && (stall_count_q != STALL_COUNT_MAX)) begin
      stall_count_d = stall_count_q + 16'd1;
    end

    // Flush suppresses stall, so a squashed hazard never enters BUBBLE.
    case (state_q)
      RUN:     state_d = stall ? BUBBLE : RUN;
      BUBBLE:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops sample pre-edge values.
    if (reset) begin
      state_q       <= RUN;
      ex_q          <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ex_q          <= ex_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.ex_rs         = ex_q.rs;
  assign bus.ex_rt         = ex_q.rt;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_ctrl       = ex_q.ctrl;
  assign bus.ex_read_data1 = ex_q.read_data1;
  assign bus.ex_read_data2 = ex_q.read_data2;
  assign bus.ex_imm        = ex_q.imm;
  assign bus.stall         = stall;
  assign bus.pc_write      = !stall && !reset;
  assign bus.if_id_write   = !stall && !reset;
  assign bus.stall_count   = stall_count_q;

endmodule

// File: tb/tb_hazard_id_ex_stage.sv
// Directed bench for hazard_id_ex_stage: inputs change 1 ns after each rising
// edge, combinational outputs are sampled 1 ns later, registered ones after the edge.
module tb_hazard_id_ex_stage;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  hazard_id_ex_stage_if bus_if ();

  hazard_id_ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [7:0] ctrl, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm, input logic fl);
    bus_if.id_rs         = rs;
    bus_if.id_rt         = rt;
    bus_if.id_rd         = rd;
    bus_if.id_ctrl       = ctrl;
    bus_if.id_read_data1 = d1;
    bus_if.id_read_data2 = d2;
    bus_if.id_imm        = imm;
    bus_if.flush         = fl;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(5'd7, 5'd8, 5'd9, 8'hFF, 32'hDEAD, 32'hBEEF, 32'h1234, 1'b0);
    tick();
    tick();
    checks++; if (bus_if.ex_ctrl !== 8'h00) begin errors++; $display("FAIL rst_ex_ctrl: got %h expected 00", bus_if.ex_ctrl); end
    checks++; if (bus_if.ex_rs !== 5'd0 || bus_if.ex_rt !== 5'd0 || bus_if.ex_rd !== 5'd0) begin errors++; $display("FAIL rst_ex_regs: got %0d/%0d/%0d expected 0/0/0", bus_if.ex_rs, bus_if.ex_rt, bus_if.ex_rd); end
    checks++; if (bus_if.ex_read_data1 !== 32'h0 || bus_if.ex_imm !== 32'h0) begin errors++; $display("FAIL rst_ex_data: got %h/%h expected 0/0", bus_if.ex_read_data1, bus_if.ex_imm); end
    checks++; if (bus_if.stall_count !== 16'h0) begin errors++; $display("FAIL rst_count: got %h expected 0000", bus_if.stall_count); end
    checks++; if (bus_if.stall !== 1'b0 || bus_if.pc_write !== 1'b0 || bus_if.if_id_write !== 1'b0) begin errors++; $display("FAIL rst_enables: got stall=%b pc=%b ifid=%b expected 0/0/0", bus_if.stall, bus_if.pc_write, bus_if.if_id_write); end
    reset = 1'b0;
    #1;
  endtask

  task automatic test_passthrough();
    drive(5'd3, 5'd4, 5'd5, 8'h84, 32'h11, 32'h22, 32'h33, 1'b0);
    checks++; if (bus_if.stall !== 1'b0 || bus_if.pc_write !== 1'b1 || bus_if.if_id_write !== 1'b1) begin errors++; $display("FAIL pass_enables: got stall=%b pc=%b ifid=%b expected 0/1/1", bus_if.stall, bus_if.pc_write, bus_if.if_id_write); end
    tick();
    checks++; if (bus_if.ex_rs !== 5'd3 || bus_if.ex_rt !== 5'd4 || bus_if.ex_rd !== 5'd5) begin errors++; $display("FAIL pass_regs: got %0d/%0d/%0d expected 3/4/5", bus_if.ex_rs, bus_if.ex_rt, bus_if.ex_rd); end
    checks++; if (bus_if.ex_ctrl !== 8'h84 || bus_if.ex_read_data1 !== 32'h11) begin errors++; $display("FAIL pass_ctrl_d1: got %h/%h expected 84/00000011", bus_if.ex_ctrl, bus_if.ex_read_data1); end
    checks++; if (bus_if.ex_read_data2 !== 32'h22 || bus_if.ex_imm !== 32'h33) begin errors++; $display("FAIL pass_d2_imm: got %h/%h expected 00000022/00000033", bus_if.ex_read_data2, bus_if.ex_imm); end
  endtask

  task automatic test_load_use();
    drive(5'd1, 5'd8, 5'd0, 8'hD8, 32'h0, 32'h0, 32'h4, 1'b0);
    tick();
    drive(5'd8, 5'd9, 5'd10, 8'h84, 32'hAA, 32'hBB, 32'h0, 1'b0);
    checks++; if (bus_if.stall !== 1'b1 || bus_if.pc_write !== 1'b0 || bus_if.if_id_write !== 1'b0) begin errors++; $display("FAIL lu_rs_enables: got stall=%b pc=%b ifid=%b expected 1/0/0", bus_if.stall, bus_if.pc_write, bus_if.if_id_write); end
    tick();
    checks++; if (bus_if.ex_ctrl !== 8'h00 || bus_if.ex_rs !== 5'd0 || bus_if.ex_read_data1 !== 32'h0) begin errors++; $display("FAIL lu_bubble: got ctrl=%h rs=%0d d1=%h expected 00/0/0", bus_if.ex_ctrl, bus_if.ex_rs, bus_if.ex_read_data1); end
    checks++; if (bus_if.stall_count !== 16'd1) begin errors++; $display("FAIL lu_count: got %0d expected 1", bus_if.stall_count); end
    checks++; if (bus_if.stall !== 1'b0 || bus_if.pc_write !== 1'b1) begin errors++; $display("FAIL lu_release: got stall=%b pc=%b expected 0/1", bus_if.stall, bus_if.pc_write); end
    tick();
    checks++; if (bus_if.ex_rs !== 5'd8 || bus_if.ex_ctrl !== 8'h84 || bus_if.ex_read_data1 !== 32'hAA) begin errors++; $display("FAIL lu_advance: got rs=%0d ctrl=%h d1=%h expected 8/84/000000aa", bus_if.ex_rs, bus_if.ex_ctrl, bus_if.ex_read_data1); end
    checks++; if (bus_if.stall_count !== 16'd1) begin errors++; $display("FAIL lu_count_hold: got %0d expected 1", bus_if.stall_count); end
    // Same load, dependency through id_rt this time.
    drive(5'd2, 5'd12, 5'd0, 8'hD8, 32'h0, 32'h0, 32'h8, 1'b0);
    tick();
    drive(5'd3, 5'd12, 5'd13, 8'h84, 32'h1, 32'h2, 32'h0, 1'b0);
    checks++; if (bus_if.stall !== 1'b1) begin errors++; $display("FAIL lu_rt_stall: got %b expected 1", bus_if.stall); end
    tick();
    checks++; if (bus_if.stall_count !== 16'd2 || bus_if.ex_ctrl !== 8'h00) begin errors++; $display("FAIL lu_rt_bubble: got count=%0d ctrl=%h expected 2/00", bus_if.stall_count, bus_if.ex_ctrl); end
    tick();
  endtask

  task automatic test_zero_reg();
    drive(5'd1, 5'd0, 5'd0, 8'hD8, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    drive(5'd0, 5'd0, 5'd6, 8'h84, 32'h55, 32'h66, 32'h0, 1'b0);
    checks++; if (bus_if.stall !== 1'b0 || bus_if.pc_write !== 1'b1) begin errors++; $display("FAIL zero_no_stall: got stall=%b pc=%b expected 0/1", bus_if.stall, bus_if.pc_write); end
    tick();
    checks++; if (bus_if.ex_ctrl !== 8'h84 || bus_if.ex_rd !== 5'd6 || bus_if.stall_count !== 16'd2) begin errors++; $display("FAIL zero_no_bubble: got ctrl=%h rd=%0d count=%0d expected 84/6/2", bus_if.ex_ctrl, bus_if.ex_rd, bus_if.stall_count); end
    // Matching register but the EX instruction is not a load.
    drive(5'd1, 5'd8, 5'd8, 8'h84, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    drive(5'd8, 5'd1, 5'd2, 8'h84, 32'h0, 32'h0, 32'h0, 1'b0);
    checks++; if (bus_if.stall !== 1'b0) begin errors++; $display("FAIL nonload_no_stall: got %b expected 0", bus_if.stall); end
    tick();
  endtask

  task automatic test_flush();
    drive(5'd1, 5'd8, 5'd0, 8'hD8, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    drive(5'd8, 5'd2, 5'd3, 8'h84, 32'h77, 32'h0, 32'h0, 1'b1);
    checks++; if (bus_if.stall !== 1'b0 || bus_if.pc_write !== 1'b1 || bus_if.if_id_write !== 1'b1) begin errors++; $display("FAIL flush_enables: got stall=%b pc=%b ifid=%b expected 0/1/1", bus_if.stall, bus_if.pc_write, bus_if.if_id_write); end
    tick();
    checks++; if (bus_if.ex_ctrl !== 8'h00 || bus_if.ex_rs !== 5'd0 || bus_if.stall_count !== 16'd2) begin errors++; $display("FAIL flush_bubble: got ctrl=%h rs=%0d count=%0d expected 00/0/2", bus_if.ex_ctrl, bus_if.ex_rs, bus_if.stall_count); end
    drive(5'd9, 5'd10, 5'd11, 8'h84, 32'h99, 32'h0, 32'h0, 1'b0);
    tick();
    checks++; if (bus_if.ex_rs !== 5'd9 || bus_if.ex_ctrl !== 8'h84 || bus_if.ex_read_data1 !== 32'h99) begin errors++; $display("FAIL flush_resume: got rs=%0d ctrl=%h d1=%h expected 9/84/00000099", bus_if.ex_rs, bus_if.ex_ctrl, bus_if.ex_read_data1); end
  endtask

  task automatic test_saturation();
    // Preload the counter just below its ceiling instead of running 65k stalls.
    dut.stall_count_q = 16'hFFFE;
    #1;
    drive(5'd1, 5'd8, 5'd0, 8'hD8, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    drive(5'd8, 5'd2, 5'd3, 8'h84, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    checks++; if (bus_if.stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h expected ffff", bus_if.stall_count); end
    drive(5'd1, 5'd8, 5'd0, 8'hD8, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    drive(5'd8, 5'd2, 5'd3, 8'h84, 32'h0, 32'h0, 32'h0, 1'b0);
    checks++; if (bus_if.stall !== 1'b1) begin errors++; $display("FAIL sat_stall: got %b expected 1", bus_if.stall); end
    tick();
    checks++; if (bus_if.stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h expected ffff", bus_if.stall_count); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    drive(5'd1, 5'd8, 5'd0, 8'hD8, 32'h5, 32'h6, 32'h7, 1'b0);
    tick();
    drive(5'd8, 5'd2, 5'd3, 8'h84, 32'h0, 32'h0, 32'h0, 1'b0);
    checks++; if (bus_if.stall !== 1'b1) begin errors++; $display("FAIL rms_pre_stall: got %b expected 1", bus_if.stall); end
    reset = 1'b1;
    #1;
    checks++; if (bus_if.stall !== 1'b0 || bus_if.pc_write !== 1'b0 || bus_if.if_id_write !== 1'b0) begin errors++; $display("FAIL rms_enables: got stall=%b pc=%b ifid=%b expected 0/0/0", bus_if.stall, bus_if.pc_write, bus_if.if_id_write); end
    tick();
    checks++; if (bus_if.ex_ctrl !== 8'h00 || bus_if.ex_rt !== 5'd0 || bus_if.ex_read_data2 !== 32'h0 || bus_if.stall_count !== 16'h0) begin errors++; $display("FAIL rms_cleared: got ctrl=%h rt=%0d d2=%h count=%h expected 00/0/0/0000", bus_if.ex_ctrl, bus_if.ex_rt, bus_if.ex_read_data2, bus_if.stall_count); end
    reset = 1'b0;
    drive(5'd3, 5'd4, 5'd5, 8'h84, 32'h11, 32'h22, 32'h33, 1'b0);
    checks++; if (bus_if.stall !== 1'b0 || bus_if.pc_write !== 1'b1) begin errors++; $display("FAIL rms_release: got stall=%b pc=%b expected 0/1", bus_if.stall, bus_if.pc_write); end
    tick();
    checks++; if (bus_if.ex_rs !== 5'd3 || bus_if.ex_ctrl !== 8'h84 || bus_if.ex_read_data1 !== 32'h11 || bus_if.stall_count !== 16'h0) begin errors++; $display("FAIL rms_pass: got rs=%0d ctrl=%h d1=%h count=%h expected 3/84/00000011/0000", bus_if.ex_rs, bus_if.ex_ctrl, bus_if.ex_read_data1, bus_if.stall_count); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(5'd0, 5'd0, 5'd0, 8'h00, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    test_reset();
    test_passthrough();
    test_load_use();
    test_zero_reg();
    test_flush();
    test_saturation();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
